// File: rtl/char_id_stream_encoder_pkg.sv
// Character range constants and the byte-to-glyph-ID mapping shared by the
// stream encoder and anything else that needs the same glyph numbering.
package char_id_pkg;

  localparam logic [7:0] DIGIT_LO   = 8'd48;
  localparam logic [7:0] DIGIT_HI   = 8'd57;
  localparam logic [7:0] UPPER_LO   = 8'd65;
  localparam logic [7:0] UPPER_HI   = 8'd90;
  localparam logic [7:0] LOWER_LO   = 8'd97;
  localparam logic [7:0] LOWER_HI   = 8'd122;
  localparam logic [7:0] EXT_LO     = 8'd128;
  localparam logic [7:0] EXT_HI     = 8'd195;

  localparam logic [7:0] DIGIT_BASE = 8'd0;
  localparam logic [7:0] UPPER_BASE = 8'd10;
  localparam logic [7:0] LOWER_BASE = 8'd36;
  localparam logic [7:0] EXT_BASE   = 8'd62;

  localparam logic [7:0] DEFAULT_INVALID_ID = 8'd255;

  function automatic logic is_valid_char(input logic [7:0] code, input logic ext_enable);
    return (code >= DIGIT_LO && code <= DIGIT_HI) ||
           (code >= UPPER_LO && code <= UPPER_HI) ||
           (code >= LOWER_LO && code <= LOWER_HI) ||
           (ext_enable && code >= EXT_LO && code <= EXT_HI);
  endfunction

  // 8-bit arithmetic; invalid codes fall back to the default invalid ID
  function automatic logic [7:0] encode_char(input logic [7:0] code, input logic ext_enable);
    logic [7:0] id;
    id = DEFAULT_INVALID_ID;
    if (code >= DIGIT_LO && code <= DIGIT_HI)
      id = code - DIGIT_LO + DIGIT_BASE;
    else if (code >= UPPER_LO && code <= UPPER_HI)
      id = code - UPPER_LO + UPPER_BASE;
    else if (code >= LOWER_LO && code <= LOWER_HI)
      id = code - LOWER_LO + LOWER_BASE;
    else if (ext_enable && code >= EXT_LO && code <= EXT_HI)
      id = code - EXT_LO + EXT_BASE;
    return id;
  endfunction

endpackage

// File: rtl/char_id_stream_encoder_if.sv
// Byte-in / glyph-ID-out streaming handshake bundle.
interface char_id_stream_encoder_if #(
  parameter int ID_WIDTH = 8
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [ID_WIDTH-1:0] out_id;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_id, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_id, out_valid
  );
endinterface

// File: rtl/char_id_stream_encoder_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy level.
module char_id_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)
        level <= level + LVL_W'(1);
      else if (!do_push && do_pop)
        level <= level - LVL_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/char_id_stream_encoder.sv
// Streaming byte-to-glyph-ID encoder: encodes at the write side, buffers IDs
// in an FWFT FIFO and counts accepted invalid bytes (saturating).
module char_id_stream_encoder
  import char_id_pkg::*;
#(
  parameter int ID_WIDTH     = 8,
  parameter int DEPTH        = 16,
  parameter int EXT_ENABLE   = 1,
  parameter int INVALID_ID   = 255,
  parameter int DROP_INVALID = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  char_id_stream_encoder_if.slave    bus,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                invalid_count
);
  localparam bit EXT_ON  = (EXT_ENABLE != 0);
  localparam bit DROP_ON = (DROP_INVALID != 0);

  logic                code_valid, accept, push, pop, full, empty;
  logic [ID_WIDTH-1:0] enc_id, head_id;

  always_comb begin
    code_valid = is_valid_char(bus.in_data, EXT_ON);
    enc_id     = code_valid ? ID_WIDTH'(encode_char(bus.in_data, EXT_ON))
                            : ID_WIDTH'(INVALID_ID);
  end

  // No full-and-popping bypass: readiness depends only on registered level
  assign bus.in_ready  = !reset && !flush && !full;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && (code_valid || !DROP_ON);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !empty;
  assign bus.out_id    = empty ? ID_WIDTH'(INVALID_ID) : head_id;

  char_id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (enc_id),
    .rd_data (head_id),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clock) begin
    if (reset)
      invalid_count <= '0;
    else if (accept && !code_valid && invalid_count != 16'hFFFF)
      invalid_count <= invalid_count + 16'd1;
  end

endmodule

// File: doc/char_id_stream_encoder.md
Name: char_id_stream_encoder

Overview:
- Streaming successor to the single-register character-ID encoder.
- Accepts a byte stream over a valid/ready handshake and maps each byte to a glyph ID. Encoded IDs are buffered in a parametrised FIFO and presented to the text renderer over a second valid/ready handshake.
- Adds flush, optional dropping of invalid codes, a FIFO fill level, and a saturating invalid-code counter.
- Fixes the old collision where invalid bytes and byte 195 both encoded to 129.

Parameters:
- ID_WIDTH, 8: width of the output glyph ID.
- DEPTH, 16: FIFO entries; power of two, at least 2.
- EXT_ENABLE, 1: when 1, bytes 128..195 map to 62..129; when 0, those bytes are invalid.
- INVALID_ID, 255: ID emitted for invalid bytes; must not lie in 0..129 and must fit in ID_WIDTH.
- DROP_INVALID, 0: when 1, invalid bytes are consumed but not written to the FIFO.

Ports:
- clock, in, 1: single clock; all logic on posedge.
- reset, in, 1: synchronous, active-high.
- flush, in, 1: discard all buffered IDs.
- in_data, in, 8: input byte.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: block accepts a byte this cycle.
- out_id, out, ID_WIDTH: glyph ID at the FIFO head.
- out_valid, out, 1: out_id is valid.
- out_ready, in, 1: consumer takes out_id this cycle.
- level, out, $clog2(DEPTH+1): number of buffered entries.
- invalid_count, out, 16: count of invalid bytes accepted; saturates.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high, on `reset`.
- Reset state: level=0, out_valid=0, out_id=INVALID_ID, invalid_count=0, pointers=0. Reset overrides flush and any handshake in the same cycle.
- Encoding (combinational, applied at the write side):
  - 48..57 -> byte-48.
  - 65..90 -> byte-65+10.
  - 97..122 -> byte-97+36.
  - 128..195 -> byte-128+62, only when EXT_ENABLE=1.
  - Anything else -> INVALID_ID.
  - Arithmetic is done in 8 bits, then zero-extended or truncated to ID_WIDTH.
- Input handshake:
  - A byte is accepted when in_valid && in_ready.
  - in_ready = !reset && !flush && (level < DEPTH).
  - in_ready is combinational from registered level, with no bypass when the FIFO is full and being popped in the same cycle.
- Write: an accepted byte is written unless it is invalid and DROP_INVALID=1. Every accepted invalid byte increments invalid_count by 1, saturating at 16'hFFFF and holding there.
- Output:
  - The FIFO is first-word-fall-through.
  - out_valid = (level != 0).
  - out_id = entry at the read pointer.
  - A pop occurs when out_valid && out_ready.
  - out_id holds stable while out_valid=1 and out_ready=0.
- Latency: a byte accepted at edge N into an empty FIFO gives out_valid=1 and the encoded out_id after edge N. Throughput is 1 ID per cycle.
- Simultaneous push and pop with level>0: level is unchanged and both pointers advance.
- Push and pop when level=0: only the push takes effect; out_valid was 0, so no pop is possible.
- Pointer wrap: read and write pointers wrap modulo DEPTH. level tracks occupancy 0..DEPTH and never over- or underflows.
- flush=1:
  - At the edge: level←0, rd_ptr←wr_ptr.
  - out_valid=0 from the next cycle.
  - No accept that cycle, because in_ready=0.
  - A pop presented in the flush cycle is ignored for level purposes.
  - invalid_count is not cleared.
- Reset mid-stream: all buffered data is lost; in_ready is 0 during the reset cycle.
- Invalid input: X on in_data while in_valid=0 must not affect state.

Decomposition:
- Package char_id_pkg holds:
  - Range constants: DIGIT_LO=48, DIGIT_HI=57, UPPER_LO=65, UPPER_HI=90, LOWER_LO=97, LOWER_HI=122, EXT_LO=128, EXT_HI=195.
  - Bases: DIGIT_BASE=0, UPPER_BASE=10, LOWER_BASE=36, EXT_BASE=62.
  - Default INVALID_ID=255.
  - A function encode_char(byte, ext_enable) returning an 8-bit ID.
- Sub-module char_id_fifo: a synchronous FWFT FIFO parametrised by WIDTH and DEPTH, with push, pop, flush, level, full and empty.
- The top level contains the encoder, the handshake glue and the invalid counter.

Test Plan:
- Reset, then push "0","A","z",195 (48,65,122,195) with out_ready=1 -> out_id 0,10,61,129, each one cycle after accept; invalid_count=0.
- Push 33 ("!") and then 200 with DROP_INVALID=0 -> out_id 255,255; invalid_count=2. Repeat with DROP_INVALID=1 -> no outputs, level stays 0, invalid_count=2. Repeat with EXT_ENABLE=0 and byte 130 -> treated as invalid.
- out_ready=0, push DEPTH=16 bytes "a".."p" -> level=16, in_ready=0, the 17th byte is not accepted. Then out_ready=1 -> 36..51 emitted in order, with pointer wrap exercised across a second fill.
- Sustained push and pop at 1/cycle with level=3 for 40 cycles -> level constant at 3 and the output order matches the input order.
- Level=5, assert flush with in_valid=1 -> input not accepted, level=0 and out_valid=0 the next cycle, invalid_count unchanged. Assert reset mid-stream -> all outputs return to their reset values the next cycle.
- Force 65536 invalid bytes -> invalid_count=16'hFFFF and it stays there on further invalid bytes.
